// File: rtl/uart_imem_loader.sv
// UART boot loader: packs little-endian words into instruction memory, holds core in reset.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module uart_imem_loader #(
    parameter int NUM_WORDS      = 256,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    localparam int ADDR_W        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM  = 3'd3;
`endif

    logic [2:0]        state_q, state_d;
    logic [1:0]        byte_q, byte_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [31:0]       shift_q, shift_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              crst_q, crst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif
    logic              timed_out;

    assign timed_out = (tmo_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        word_d  = word_q;
        tmo_d   = tmo_q;
        shift_d = shift_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        crst_d  = crst_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_RECV;
                    byte_d  = 2'd0;
                    word_d  = '0;
                    tmo_d   = '0;
                    crst_d  = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end
            end
            S_RECV: begin
                if (rx_valid) begin
                    tmo_d   = '0;
                    byte_d  = byte_q + 2'd1;
                    // Bytes shift in from the top so byte 0 ends up in [7:0].
                    shift_d = {rx_data, shift_q[31:8]};
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data;
`endif
                    if (byte_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = word_q;
                        wdata_d = shift_d;
                        if (word_q == LAST_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d = S_FLUSH;
`endif
                        end else begin
                            word_d = word_q + 1'b1;
                        end
                    end
                end else if (timed_out) begin
                    state_d = S_ERROR;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
                crst_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (rx_valid) begin
                    busy_d = 1'b0;
                    if (rx_data == csum_q) begin
                        state_d = S_DONE;
                        crst_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end else if (timed_out) begin
                    state_d = S_ERROR;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            byte_q  <= 2'd0;
            word_q  <= '0;
            tmo_q   <= '0;
            shift_q <= 32'h0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            crst_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            tmo_q   <= tmo_d;
            shift_q <= shift_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            crst_q  <= crst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_reset = crst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = err_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Randomized bench for uart_imem_loader against a byte-list reference model.
// Honours LOADER_CHECKSUM_EN the same way as the design.
module tb_uart_imem_loader;

    localparam int NW  = 4;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        imem_we;
    logic [1:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        error;

    int   n_vec = 0;
    int   n_bad = 0;
    int   nwr = 0;
    int   b2b = 0;
    logic prev_we = 1'b0;

    always #5 clk = ~clk;

    uart_imem_loader #(
        .NUM_WORDS(NW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .core_reset(core_reset),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always @(negedge clk) begin
        if (imem_we) begin
            nwr++;
            if (prev_we) b2b++;
        end
        prev_we = imem_we;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_we"}, imem_we, 0);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_wdata"}, imem_wdata, 0);
        chk({tag, "_crst"}, core_reset, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, error, 0);
    endtask

    // Model: byte list -> words sum(b[4w+k] << 8k); status from byte count and XOR.
    task automatic run_load(input int nbytes, input bit det, input bit poke,
                            input bit start_rx, input bit csum_bad);
        byte unsigned b[$];
        byte unsigned x;
        logic [31:0]  w;
        int           base;
        int           gap;
        base = nwr;
        x = 8'h00;
        start = 1'b1;
        if (start_rx) begin
            rx_valid = 1'b1;
            rx_data  = 8'hAA;
        end
        tick();
        start = 1'b0;
        rx_valid = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_crst", core_reset, 1);
        chk("start_done", done, 0);
        chk("start_err", error, 0);
        for (int i = 0; i < nbytes; i++) begin
            b.push_back(det ? 8'(i) : 8'($urandom));
            x ^= b[i];
            gap = det ? 9 : int'($urandom_range(0, 5));
            if (poke && i == 6) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                chk("poke_busy", busy, 1);
            end
            repeat (gap) tick();
            send(b[i]);
            if (i % 4 == 3) begin
                w = 32'h0;
                for (int k = 0; k < 4; k++)
                    w = w + (32'(b[i - 3 + k]) << (8 * k));
                chk("wr_we", imem_we, 1);
                chk("wr_addr", imem_addr, i / 4);
                chk("wr_data", imem_wdata, w);
            end else begin
                chk("nowr_we", imem_we, 0);
            end
        end
        if (nbytes == 4 * NW) begin
`ifdef LOADER_CHECKSUM_EN
            chk("csum_busy", busy, 1);
            repeat ($urandom_range(0, 5)) tick();
            send(csum_bad ? (x ^ 8'h01) : x);
            chk("end_done", done, csum_bad ? 0 : 1);
            chk("end_err", error, csum_bad ? 1 : 0);
            chk("end_crst", core_reset, csum_bad ? 1 : 0);
            chk("end_busy", busy, 0);
`else
            chk("flush_busy", busy, 1);
            chk("flush_done", done, 0);
            tick();
            chk("end_done", done, 1);
            chk("end_crst", core_reset, 0);
            chk("end_busy", busy, 0);
            chk("end_err", error, 0);
`endif
        end else begin
            repeat (TMO - 1) tick();
            chk("tmo_early", error, 0);
            tick();
            chk("tmo_err", error, 1);
            chk("tmo_crst", core_reset, 1);
            chk("tmo_busy", busy, 0);
            chk("tmo_done", done, 0);
        end
        tick();
        chk("nwrites", nwr - base, nbytes / 4);
    endtask

    initial begin
        #1;
        outs_zero("por");
        tick();
        tick();
        reset = 1'b0;

        send(8'hAA);
        chk("idle_rx_we", imem_we, 0);
        chk("idle_rx_busy", busy, 0);

        run_load(4 * NW, 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'hAA);
        chk("done_rx_we", imem_we, 0);
`ifdef LOADER_CHECKSUM_EN
        chk("done_rx_done", done, 1);
        run_load(4 * NW, 1'b1, 1'b0, 1'b0, 1'b1);
`else
        chk("done_rx_done", done, 1);
`endif

        run_load(5, 1'b1, 1'b0, 1'b0, 1'b0);
        run_load(4 * NW, 1'b0, 1'b1, 1'b1, 1'b0);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) send(8'($urandom));
        #3;
        reset = 1'b1;
        #1;
        outs_zero("arst");
        tick();
        tick();
        reset = 1'b0;
        chk("arst_crst", core_reset, 0);
        run_load(4 * NW, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 1) == 1)
                run_load(4 * NW, 1'b0, 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                run_load(int'($urandom_range(0, 4 * NW - 1)), 1'b0,
                         1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        chk("we_b2b", b2b, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
